// File: rtl/fx_scheduler.sv
// rtl/fx_scheduler.sv - round-robin time-multiplexer of one shared streaming effect unit across NCH channels
//
// Optional build macro: SCHED_STATS_EN (adds stat_done / stat_drop counters)
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   in_data/in_valid/in_ready   per-channel sample streams (channel i at in_data[i*W +: W])
//   chan_on                     per-channel effect enable, sampled at grant
//   fx_data/fx_valid/fx_ready   sample issued to the effect unit
//   fx_on                       effect enable travelling with the issued sample
//   fx_res_data/fx_res_valid    effect result, only accepted while waiting
//   out_data/out_chan/out_valid/out_ready  tagged result stream to the mixer
//   timeout_err                 sticky flag, set when a sample is dropped for lack of a result
//   stat_done/stat_drop         saturating completion / drop counters (SCHED_STATS_EN only)
module fx_scheduler #(
    parameter int NCH     = 4,
    parameter int W       = 24,
    parameter int TIMEOUT = 255,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0]   in_valid,
    output logic [NCH-1:0]   in_ready,
    input  logic [NCH-1:0]   chan_on,
    output logic [W-1:0]     fx_data,
    output logic             fx_valid,
    input  logic             fx_ready,
    output logic             fx_on,
    input  logic [W-1:0]     fx_res_data,
    input  logic             fx_res_valid,
    output logic [W-1:0]     out_data,
    output logic [CW-1:0]    out_chan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             timeout_err
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]      stat_done,
    output logic [7:0]       stat_drop
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   last_grant;
    logic [CW-1:0]   cur_chan;
    logic [15:0]     wait_cnt;
    logic            grant_found;
    logic [CW-1:0]   grant_idx;
    logic [CW-1:0]   cand;
    logic [W-1:0]    grant_data;
    logic            timeout_hit;

    // Search upward from the channel after the last one served, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CW'((int'(last_grant) + k) % NCH);
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == CW'(i)) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    // A result arriving on the last allowed cycle takes priority over the drop.
    assign timeout_hit = (state_q == S_WAIT) && !fx_res_valid &&
                         (wait_cnt == 16'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        in_ready  = '0;
        fx_valid  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by reset so no channel sees an accept that will be discarded.
                if (grant_found && !reset) begin
                    in_ready[grant_idx] = 1'b1;
                    state_d             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fx_valid = 1'b1;
                if (fx_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fx_res_valid) begin
                    state_d = S_DELIVER;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_DELIVER: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_grant  <= CW'(NCH - 1);
            cur_chan    <= '0;
            wait_cnt    <= '0;
            fx_data     <= '0;
            fx_on       <= 1'b0;
            out_data    <= '0;
            out_chan    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        fx_data  <= grant_data;
                        fx_on    <= chan_on[grant_idx];
                        cur_chan <= grant_idx;
                    end
                end
                S_ISSUE: begin
                    if (fx_ready) begin
                        wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (fx_res_valid) begin
                        out_data <= fx_res_data;
                        out_chan <= cur_chan;
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        last_grant  <= cur_chan;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_DELIVER: begin
                    if (out_ready) begin
                        last_grant <= cur_chan;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_done <= '0;
            stat_drop <= '0;
        end else begin
            if ((state_q == S_DELIVER) && out_ready && (stat_done != 16'hFFFF)) begin
                stat_done <= stat_done + 16'd1;
            end
            if (timeout_hit && (stat_drop != 8'hFF)) begin
                stat_drop <= stat_drop + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fx_scheduler.sv
// tb/tb_fx_scheduler.sv - self-checking bench for fx_scheduler with a transaction-level reference model
module tb_fx_scheduler;
    localparam int NCH = 4;
    localparam int W   = 24;
    localparam int TO  = 16;
    localparam int CW  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic [NCH-1:0]   chan_on;
    logic [W-1:0]     fx_data;
    logic             fx_valid;
    logic             fx_ready;
    logic             fx_on;
    logic [W-1:0]     fx_res_data;
    logic             fx_res_valid;
    logic [W-1:0]     out_data;
    logic [CW-1:0]    out_chan;
    logic             out_valid;
    logic             out_ready;
    logic             timeout_err;
`ifdef SCHED_STATS_EN
    logic [15:0]      stat_done;
    logic [7:0]       stat_drop;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fx_scheduler #(.NCH(NCH), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .chan_on(chan_on),
        .fx_data(fx_data), .fx_valid(fx_valid), .fx_ready(fx_ready), .fx_on(fx_on),
        .fx_res_data(fx_res_data), .fx_res_valid(fx_res_valid),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
        .timeout_err(timeout_err)
`ifdef SCHED_STATS_EN
        , .stat_done(stat_done), .stat_drop(stat_drop)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_data = '0; chan_on = '0; fx_ready = 1'b0;
        fx_res_valid = 1'b0; fx_res_data = '0; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        in_valid = '1;
        step();
        #1;
        total++; if ({in_ready, fx_data, fx_valid, fx_on, out_data, out_chan, out_valid, timeout_err} !== '0) begin
            bad++; $display("FAIL reset_outputs got in_ready=%b fx_valid=%b out_valid=%b err=%b exp all 0", in_ready, fx_valid, out_valid, timeout_err);
        end
        reset = 1'b0;
        in_valid = '0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 4'b0001; in_data[0 +: W] = 24'h000100; chan_on = 4'b0001;
        fx_ready = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL single_in_ready got=%b exp=0001", in_ready); end
        step();
        in_valid = '0;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL single_in_ready_pulse got=%b exp=0000", in_ready); end
        total++; if ({fx_valid, fx_on, fx_data} !== {2'b11, 24'h000100}) begin
            bad++; $display("FAIL single_issue got v=%b on=%b d=%h exp v=1 on=1 d=000100", fx_valid, fx_on, fx_data);
        end
        step();
        #1;
        total++; if ({fx_valid, fx_on} !== 2'b01) begin bad++; $display("FAIL single_wait got v=%b on=%b exp v=0 on=1", fx_valid, fx_on); end
        step();
        fx_res_valid = 1'b1; fx_res_data = 24'h000080;
        #1;
        step();
        fx_res_valid = 1'b0;
        #1;
        total++; if ({out_valid, out_data, out_chan, timeout_err} !== {1'b1, 24'h000080, 2'd0, 1'b0}) begin
            bad++; $display("FAIL single_out got v=%b d=%h ch=%0d err=%b exp v=1 d=000080 ch=0 err=0", out_valid, out_data, out_chan, timeout_err);
        end
        step();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_out_drop got=%b exp=0", out_valid); end
    endtask

    // Randomised traffic against a transaction model: one sample in flight,
    // round-robin grant from the channel after the last one granted.
    task automatic run_random(input bit all_valid, input int ncyc, input int want_done);
        logic [W-1:0]   dat [NCH];
        bit             pend [NCH];
        bit             have_tx, issued, got_res, tx_on;
        int             tx_chan, exp_last, cyc, res_cyc, ndone, g, idx;
        logic [W-1:0]   tx_data, res_data;
        logic [NCH-1:0] exp_rdy;
        do_reset();
        exp_last = NCH - 1; have_tx = 0; issued = 0; got_res = 0; tx_on = 0;
        cyc = 0; res_cyc = -1; ndone = 0; tx_chan = 0; tx_data = '0; res_data = '0;
        for (int i = 0; i < NCH; i++) begin
            pend[i] = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
            dat[i]  = W'($urandom);
        end
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < NCH; i++) begin
                in_valid[i] = pend[i];
                in_data[i*W +: W] = dat[i];
            end
            chan_on      = NCH'($urandom);
            fx_ready     = ($urandom_range(0, 2) != 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            fx_res_valid = (cyc == res_cyc);
            fx_res_data  = (cyc == res_cyc) ? res_data : W'($urandom);
            #1;
            exp_rdy = '0;
            g = -1;
            if (!have_tx) begin
                for (int k = 1; k <= NCH; k++) begin
                    idx = (exp_last + k) % NCH;
                    if (g < 0 && pend[idx]) g = idx;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
            total++; if (fx_valid !== (have_tx && !issued)) begin bad++; $display("FAIL rnd_fx_valid cyc=%0d got=%b exp=%b", cyc, fx_valid, have_tx && !issued); end
            total++; if (out_valid !== got_res) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, got_res); end
            if (g >= 0) begin
                have_tx = 1; tx_chan = g; tx_data = dat[g]; tx_on = chan_on[g];
                exp_last = g; pend[g] = 0;
            end else if (have_tx && !issued && fx_ready) begin
                total++; if ({fx_data, fx_on} !== {tx_data, tx_on}) begin
                    bad++; $display("FAIL rnd_fx_payload cyc=%0d got d=%h on=%b exp d=%h on=%b", cyc, fx_data, fx_on, tx_data, tx_on);
                end
                issued = 1;
                res_cyc = cyc + $urandom_range(1, 3);
                res_data = W'($urandom);
            end else if (cyc == res_cyc) begin
                got_res = 1; res_cyc = -1;
            end else if (got_res && out_ready) begin
                total++; if ({out_data, out_chan} !== {res_data, CW'(tx_chan)}) begin
                    bad++; $display("FAIL rnd_out_payload cyc=%0d got d=%h ch=%0d exp d=%h ch=%0d", cyc, out_data, out_chan, res_data, tx_chan);
                end
                if (all_valid) begin
                    total++; if (out_chan !== CW'(ndone % NCH)) begin
                        bad++; $display("FAIL rr_order n=%0d got ch=%0d exp ch=%0d", ndone, out_chan, ndone % NCH);
                    end
                end
                ndone++; have_tx = 0; issued = 0; got_res = 0;
            end
            step();
            cyc++;
            for (int i = 0; i < NCH; i++) begin
                if (!pend[i] && (all_valid || $urandom_range(0, 2) == 0)) begin
                    pend[i] = 1; dat[i] = W'($urandom);
                end
            end
            if (want_done > 0 && ndone >= want_done) break;
        end
        if (want_done > 0) begin
            total++; if (ndone < want_done) begin bad++; $display("FAIL rnd_progress got=%0d exp>=%0d", ndone, want_done); end
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        run_random(1'b1, 400, 12);
    endtask

    task automatic test_random_traffic();
        run_random(1'b0, 800, 20);
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 4'b0100; in_data[2*W +: W] = 24'h7FF123; chan_on = 4'b0100;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_grant got=%b exp=0100", in_ready); end
        step();
        in_valid = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if ({fx_valid, fx_data, in_ready} !== {1'b1, 24'h7FF123, 4'b0000}) begin
                bad++; $display("FAIL bp_issue_hold i=%0d got v=%b d=%h rdy=%b exp v=1 d=7ff123 rdy=0000", i, fx_valid, fx_data, in_ready);
            end
            step();
        end
        fx_ready = 1'b1;
        #1;
        step();
        fx_ready = 1'b0; fx_res_valid = 1'b1; fx_res_data = 24'h800001;
        #1;
        step();
        fx_res_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) out_ready = 1'b1;
            #1;
            total++; if ({out_valid, out_data, out_chan, in_ready} !== {1'b1, 24'h800001, 2'd2, 4'b0000}) begin
                bad++; $display("FAIL bp_out_hold i=%0d got v=%b d=%h ch=%0d rdy=%b exp v=1 d=800001 ch=2 rdy=0000", i, out_valid, out_data, out_chan, in_ready);
            end
            step();
        end
        #1;
        total++; if ({out_valid, in_ready} !== {1'b0, 4'b1000}) begin
            bad++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1000", out_valid, in_ready);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        in_valid = 4'b0010; fx_ready = 1'b1; out_ready = 1'b1;
        #1;
        step();
        in_valid = '0;
        #1;
        step();
        in_valid = 4'b0100; in_data[2*W +: W] = 24'h00AA55;
        for (int i = 0; i < TO; i++) begin
            #1;
            total++; if ({in_ready, out_valid} !== 5'b0) begin
                bad++; $display("FAIL to_wait i=%0d got rdy=%b v=%b exp rdy=0000 v=0", i, in_ready, out_valid);
            end
            step();
        end
        #1;
        total++; if ({in_ready, timeout_err} !== {4'b0100, 1'b1}) begin
            bad++; $display("FAIL to_return got rdy=%b err=%b exp rdy=0100 err=1", in_ready, timeout_err);
        end
        step();
        in_valid = '0; fx_ready = 1'b0; fx_res_valid = 1'b1; fx_res_data = 24'hDEAD00;
        #1;
        step();
        fx_res_valid = 1'b0; fx_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL to_late_ignored got=%b exp=0", out_valid); end
        step();
        fx_ready = 1'b0;
        #1;
        step();
        fx_res_valid = 1'b1; fx_res_data = 24'h123456;
        #1;
        step();
        fx_res_valid = 1'b0;
        #1;
        total++; if ({out_valid, out_data, out_chan, timeout_err} !== {1'b1, 24'h123456, 2'd2, 1'b1}) begin
            bad++; $display("FAIL to_next_ok got v=%b d=%h ch=%0d err=%b exp v=1 d=123456 ch=2 err=1", out_valid, out_data, out_chan, timeout_err);
        end
        step();
    endtask

    task automatic test_final_cycle_result();
        do_reset();
        in_valid = 4'b1000; in_data[3*W +: W] = 24'h333333; fx_ready = 1'b1; out_ready = 1'b1;
        #1;
        step();
        in_valid = '0;
        #1;
        step();
        for (int i = 0; i < TO - 1; i++) begin
            #1;
            step();
        end
        fx_res_valid = 1'b1; fx_res_data = 24'h0ABCDE;
        #1;
        step();
        fx_res_valid = 1'b0;
        #1;
        total++; if ({out_valid, out_data, out_chan, timeout_err} !== {1'b1, 24'h0ABCDE, 2'd3, 1'b0}) begin
            bad++; $display("FAIL edge_result_wins got v=%b d=%h ch=%0d err=%b exp v=1 d=0abcde ch=3 err=0", out_valid, out_data, out_chan, timeout_err);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 4'b0010; fx_ready = 1'b1; out_ready = 1'b1;
        #1;
        step();
        in_valid = '0;
        #1;
        step();
        fx_res_valid = 1'b1; fx_res_data = 24'h111111;
        #1;
        step();
        fx_res_valid = 1'b0;
        #1;
        step();
        in_valid = 4'b1000; in_data[3*W +: W] = 24'hFEDCBA; chan_on = 4'b1000;
        #1;
        step();
        in_valid = '0;
        #1;
        step();
        reset = 1'b1;
        #1;
        step();
        #1;
        total++; if ({in_ready, fx_data, fx_valid, fx_on, out_data, out_chan, out_valid, timeout_err} !== '0) begin
            bad++; $display("FAIL reset_in_wait got d=%h on=%b v=%b exp all 0", fx_data, fx_on, out_valid);
        end
        reset = 1'b0;
        in_valid = 4'b0101;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready); end
        step();
        idle_inputs();
    endtask

`ifdef SCHED_STATS_EN
    task automatic one_txn(input int ch, input bit respond);
        in_valid = NCH'(1 << ch); fx_ready = 1'b1; out_ready = 1'b1;
        #1;
        step();
        in_valid = '0;
        #1;
        step();
        if (respond) begin
            fx_res_valid = 1'b1;
            #1;
            step();
            fx_res_valid = 1'b0;
            #1;
            step();
        end else begin
            repeat (TO) begin
                #1;
                step();
            end
        end
    endtask

    task automatic test_stats();
        do_reset();
        #1;
        total++; if ({stat_done, stat_drop} !== 24'h0) begin bad++; $display("FAIL stats_reset got done=%0d drop=%0d exp 0 0", stat_done, stat_drop); end
        one_txn(0, 1'b1);
        one_txn(1, 1'b0);
        one_txn(2, 1'b1);
        one_txn(3, 1'b1);
        #1;
        total++; if ({stat_done, stat_drop} !== {16'd3, 8'd1}) begin
            bad++; $display("FAIL stats_count got done=%0d drop=%0d exp done=3 drop=1", stat_done, stat_drop);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_random_traffic();
        test_backpressure();
        test_timeout();
        test_final_cycle_result();
        test_reset_mid();
`ifdef SCHED_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
